// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one single-port BRAM: picks one winner per cycle,
// registers the BRAM command and steers the read data back to its owner two cycles later.
module bram_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int POLICY       = 0,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req_i,
  output logic              inst_gnt_o,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              inst_we_i,
  input  logic [3:0]        inst_be_i,
  input  logic [31:0]       inst_wdata_i,
  output logic              inst_rvalid_o,
  output logic [31:0]       inst_rdata_o,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [3:0]        bram_we_o,
  output logic [31:0]       bram_wrdata_o,
  input  logic [31:0]       bram_rddata_i,
  output logic [CNT_W-1:0]  inst_stall_cnt_o,
  output logic [CNT_W-1:0]  data_stall_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              inst_win, data_win;
  logic              rr_data_q, rr_data_d;
  logic [3:0]        starve_q, starve_d;
  logic [CNT_W-1:0]  inst_stall_q, inst_stall_d, data_stall_q, data_stall_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_we;
  logic [31:0]       cmd_wdata;
  logic              en_q, inst_v1_q, data_v1_q, inst_rv_q, data_rv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q, inst_rdata_q, data_rdata_q;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{inst_addr_i[1:0], data_addr_i[1:0]};

  // Winner selection; rr_data_q set means data is favoured on the next contested cycle.
  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (inst_req_i && data_req_i) begin
      if (POLICY == 0) begin
        inst_win = !rr_data_q;
      end else begin
        inst_win = (starve_q == LIMIT);
      end
      data_win = !inst_win;
    end else begin
      inst_win = inst_req_i;
      data_win = data_req_i;
    end
  end

  // Arbitration history, stall counters and the winner's command.
  always_comb begin
    rr_data_d = rr_data_q;
    if (inst_win) begin
      rr_data_d = 1'b1;
    end else if (data_win) begin
      rr_data_d = 1'b0;
    end else begin
      rr_data_d = rr_data_q;
    end

    starve_d = starve_q;
    if (!inst_req_i || inst_win) begin
      starve_d = 4'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end

    inst_stall_d = inst_stall_q;
    if (inst_req_i && !inst_win && (inst_stall_q != {CNT_W{1'b1}})) begin
      inst_stall_d = inst_stall_q + CNT_W'(1);
    end else begin
      inst_stall_d = inst_stall_q;
    end

    data_stall_d = data_stall_q;
    if (data_req_i && !data_win && (data_stall_q != {CNT_W{1'b1}})) begin
      data_stall_d = data_stall_q + CNT_W'(1);
    end else begin
      data_stall_d = data_stall_q;
    end

    if (data_win) begin
      cmd_addr  = {2'b00, data_addr_i[ADDR_W-1:2]};
      cmd_we    = data_we_i ? data_be_i : 4'b0000;
      cmd_wdata = data_wdata_i;
    end else begin
      cmd_addr  = {2'b00, inst_addr_i[ADDR_W-1:2]};
      cmd_we    = inst_we_i ? inst_be_i : 4'b0000;
      cmd_wdata = inst_wdata_i;
    end
  end

  // Command stage, response-owner pipeline and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_data_q    <= 1'b0;
      starve_q     <= 4'd0;
      inst_stall_q <= {CNT_W{1'b0}};
      data_stall_q <= {CNT_W{1'b0}};
      en_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      we_q         <= 4'b0000;
      wdata_q      <= 32'h0000_0000;
      inst_v1_q    <= 1'b0;
      data_v1_q    <= 1'b0;
      inst_rv_q    <= 1'b0;
      data_rv_q    <= 1'b0;
      inst_rdata_q <= 32'h0000_0000;
      data_rdata_q <= 32'h0000_0000;
    end else begin
      rr_data_q    <= rr_data_d;
      starve_q     <= starve_d;
      inst_stall_q <= inst_stall_d;
      data_stall_q <= data_stall_d;
      en_q         <= inst_win || data_win;
      inst_v1_q    <= inst_win;
      data_v1_q    <= data_win;
      inst_rv_q    <= inst_v1_q;
      data_rv_q    <= data_v1_q;
      if (inst_win || data_win) begin
        addr_q  <= cmd_addr;
        we_q    <= cmd_we;
        wdata_q <= cmd_wdata;
      end else begin
        addr_q  <= addr_q;
        we_q    <= 4'b0000;
        wdata_q <= wdata_q;
      end
      if (inst_rv_q) begin
        inst_rdata_q <= bram_rddata_i;
      end else begin
        inst_rdata_q <= inst_rdata_q;
      end
      if (data_rv_q) begin
        data_rdata_q <= bram_rddata_i;
      end else begin
        data_rdata_q <= data_rdata_q;
      end
    end
  end

  assign inst_gnt_o       = inst_win;
  assign data_gnt_o       = data_win;
  assign bram_en_o        = en_q;
  assign bram_addr_o      = addr_q;
  assign bram_we_o        = we_q;
  assign bram_wrdata_o    = wdata_q;
  assign inst_rvalid_o    = inst_rv_q;
  assign data_rvalid_o    = data_rv_q;
  // The BRAM word is live only in the response cycle; the held copy covers the rest.
  assign inst_rdata_o     = inst_rv_q ? bram_rddata_i : inst_rdata_q;
  assign data_rdata_o     = data_rv_q ? bram_rddata_i : data_rdata_q;
  assign inst_stall_cnt_o = inst_stall_q;
  assign data_stall_cnt_o = data_stall_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives a round-robin arbiter (dut0) and a data-priority arbiter with 4-bit counters (dut1),
// each with its own BRAM model, and checks them against a scoreboard of expected grants/responses.
module tb_bram_port_arbiter;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          inst_req [2], inst_gnt [2], inst_we [2], inst_rvalid [2];
  logic          data_req [2], data_gnt [2], data_we [2], data_rvalid [2];
  logic [AW-1:0] inst_addr [2], data_addr [2], bram_addr [2];
  logic [3:0]    inst_be [2], data_be [2], bram_we [2];
  logic [31:0]   inst_wdata [2], data_wdata [2], inst_rdata [2], data_rdata [2];
  logic [31:0]   bram_wrdata [2], bram_rd [2];
  logic          bram_en [2];
  logic [31:0]   istall0, dstall0;
  logic [3:0]    istall1, dstall1;

  bram_port_arbiter #(.ADDR_W(AW), .POLICY(0), .STARVE_LIMIT(4), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .inst_req_i(inst_req[0]), .inst_gnt_o(inst_gnt[0]), .inst_addr_i(inst_addr[0]),
    .inst_we_i(inst_we[0]), .inst_be_i(inst_be[0]), .inst_wdata_i(inst_wdata[0]),
    .inst_rvalid_o(inst_rvalid[0]), .inst_rdata_o(inst_rdata[0]),
    .data_req_i(data_req[0]), .data_gnt_o(data_gnt[0]), .data_addr_i(data_addr[0]),
    .data_we_i(data_we[0]), .data_be_i(data_be[0]), .data_wdata_i(data_wdata[0]),
    .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
    .bram_en_o(bram_en[0]), .bram_addr_o(bram_addr[0]), .bram_we_o(bram_we[0]),
    .bram_wrdata_o(bram_wrdata[0]), .bram_rddata_i(bram_rd[0]),
    .inst_stall_cnt_o(istall0), .data_stall_cnt_o(dstall0));

  bram_port_arbiter #(.ADDR_W(AW), .POLICY(1), .STARVE_LIMIT(4), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .inst_req_i(inst_req[1]), .inst_gnt_o(inst_gnt[1]), .inst_addr_i(inst_addr[1]),
    .inst_we_i(inst_we[1]), .inst_be_i(inst_be[1]), .inst_wdata_i(inst_wdata[1]),
    .inst_rvalid_o(inst_rvalid[1]), .inst_rdata_o(inst_rdata[1]),
    .data_req_i(data_req[1]), .data_gnt_o(data_gnt[1]), .data_addr_i(data_addr[1]),
    .data_we_i(data_we[1]), .data_be_i(data_be[1]), .data_wdata_i(data_wdata[1]),
    .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
    .bram_en_o(bram_en[1]), .bram_addr_o(bram_addr[1]), .bram_we_o(bram_we[1]),
    .bram_wrdata_o(bram_wrdata[1]), .bram_rddata_i(bram_rd[1]),
    .inst_stall_cnt_o(istall1), .data_stall_cnt_o(dstall1));

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | (i * 32'h0000_0101);
  endfunction

  // Read-first BRAM models, 64 words each (testbench addresses stay below 0x100).
  logic [31:0] hwmem [2][64];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 64; i++) hwmem[d][i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (bram_en[d]) begin
          bram_rd[d] <= hwmem[d][bram_addr[d][5:0]];
          for (int b = 0; b < 4; b++)
            if (bram_we[d][b]) hwmem[d][bram_addr[d][5:0]][8*b +: 8] <= bram_wrdata[d][8*b +: 8];
        end
      end
    end
  end

  typedef struct {bit owner; logic [31:0] data; int due;} rsp_t;
  rsp_t rq [2][$];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   ref_mem [2][64];
  bit            last_win_data [2];
  int            denials [2];
  longint        m_istall [2], m_dstall [2], sat [2];
  bit            exp_en [2];
  logic [AW-1:0] exp_addr [2];
  logic [3:0]    exp_we [2];
  logic [31:0]   exp_wd [2];
  bit            granted [2][2], pend [2][2];
  logic [AW-1:0] t_addr [2][2];
  bit            t_we [2][2];
  logic [3:0]    t_be [2][2];
  logic [31:0]   t_wd [2][2];
  logic [31:0]   last_rd [2][2];
  string         gseq [2];

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, d, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      last_win_data[d] = 1'b1;
      denials[d] = 0;
      m_istall[d] = 0;
      m_dstall[d] = 0;
      exp_en[d] = 1'b0;
      rq[d].delete();
      gseq[d] = "";
      inst_req[d] = 1'b0;
      data_req[d] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        granted[d][r] = 1'b0;
        pend[d][r] = 1'b0;
        last_rd[d][r] = 32'h0;
      end
    end
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_bram", d, {bram_en[d], bram_addr[d], bram_we[d], bram_wrdata[d]}, 64'h0);
      chk("rst_rvalid", d, {inst_rvalid[d], data_rvalid[d]}, 64'h0);
      chk("rst_rdata", d, {inst_rdata[d], data_rdata[d]}, 64'h0);
    end
    chk("rst_cnt", 0, {istall0, dstall0}, 64'h0);
    chk("rst_cnt", 1, {istall1, dstall1}, 64'h0);
  endtask

  // Reference arbitration: spec rules applied to the current requests and history.
  task automatic check_cycle(input int d);
    bit ir, dr, gi, gd, r;
    logic [63:0] ist, dst;
    logic [5:0] w;
    rsp_t e;
    ir = inst_req[d];
    dr = data_req[d];
    if (ir && dr) begin
      gi = (d == 0) ? last_win_data[d] : (denials[d] == 4);
      gd = !gi;
    end else begin
      gi = ir;
      gd = dr;
    end
    chk("grant", d, {62'd0, inst_gnt[d], data_gnt[d]}, {62'd0, gi, gd});
    if (!ir || gi) denials[d] = 0;
    else if (denials[d] < 4) denials[d]++;
    if (gi) last_win_data[d] = 1'b0;
    if (gd) last_win_data[d] = 1'b1;

    chk("bram_en", d, {63'd0, bram_en[d]}, {63'd0, exp_en[d]});
    if (exp_en[d])
      chk("bram_cmd", d, {bram_addr[d], bram_we[d], bram_wrdata[d]}, {exp_addr[d], exp_we[d], exp_wd[d]});

    ist = (d == 0) ? {32'd0, istall0} : {60'd0, istall1};
    dst = (d == 0) ? {32'd0, dstall0} : {60'd0, dstall1};
    chk("inst_stall", d, ist, m_istall[d]);
    chk("data_stall", d, dst, m_dstall[d]);
    if (ir && !gi && m_istall[d] < sat[d]) m_istall[d]++;
    if (dr && !gd && m_dstall[d] < sat[d]) m_dstall[d]++;

    exp_en[d] = gi || gd;
    if (gi || gd) begin
      r = gd;
      w = t_addr[d][r][7:2];
      exp_addr[d] = {2'b00, t_addr[d][r][AW-1:2]};
      exp_we[d] = t_we[d][r] ? t_be[d][r] : 4'b0000;
      exp_wd[d] = t_wd[d][r];
      e.owner = r;
      e.data = ref_mem[d][w];
      e.due = cyc + 2;
      rq[d].push_back(e);
      for (int b = 0; b < 4; b++)
        if (exp_we[d][b]) ref_mem[d][w][8*b +: 8] = t_wd[d][r][8*b +: 8];
      gseq[d] = {gseq[d], gi ? "I" : "D"};
    end
    granted[d][0] = gi;
    granted[d][1] = gd;
  endtask

  // mode 0: no new requests, 1: always request, 2: request with 60% probability.
  task automatic drive(input int mode);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (granted[d][r]) pend[d][r] = 1'b0;
        granted[d][r] = 1'b0;
        if (!pend[d][r] && (mode == 1 || (mode == 2 && $urandom_range(0, 99) < 60))) begin
          pend[d][r] = 1'b1;
          t_addr[d][r] = AW'($urandom_range(0, 255));
          t_we[d][r] = 1'($urandom_range(0, 1));
          t_be[d][r] = 4'($urandom);
          t_wd[d][r] = $urandom;
        end
      end
      inst_req[d] = pend[d][0];
      inst_addr[d] = t_addr[d][0];
      inst_we[d] = t_we[d][0];
      inst_be[d] = t_be[d][0];
      inst_wdata[d] = t_wd[d][0];
      data_req[d] = pend[d][1];
      data_addr[d] = t_addr[d][1];
      data_we[d] = t_we[d][1];
      data_be[d] = t_be[d][1];
      data_wdata[d] = t_wd[d][1];
    end
  endtask

  task automatic step(input int mode);
    drive(mode);
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (!(pend[0][0] || pend[0][1] || pend[1][0] || pend[1][1] ||
            rq[0].size() != 0 || rq[1].size() != 0)) break;
      step(0);
    end
    chk("drain_q", 0, rq[0].size(), 0);
    chk("drain_q", 1, rq[1].size(), 0);
  endtask

  // Response monitor: pops the scoreboard whenever a DUT presents rvalid.
  task automatic mon(input int d);
    bit ri, rv;
    rsp_t e;
    ri = inst_rvalid[d];
    rv = data_rvalid[d];
    chk("rvalid_excl", d, {63'd0, ri && rv}, 64'd0);
    if (ri || rv) begin
      if (rq[d].size() == 0) begin
        chk("rsp_unexpected", d, {62'd0, ri, rv}, 64'd0);
      end else begin
        e = rq[d].pop_front();
        chk("rsp_owner", d, {63'd0, rv}, {63'd0, e.owner});
        chk("rsp_cycle", d, cyc, e.due);
        chk("rsp_data", d, rv ? data_rdata[d] : inst_rdata[d], e.data);
        last_rd[d][e.owner] = e.data;
      end
    end else if (rq[d].size() != 0 && rq[d][0].due < cyc) begin
      chk("rsp_missing", d, cyc, rq[d][0].due);
      void'(rq[d].pop_front());
    end
    if (!ri) chk("inst_rdata_hold", d, inst_rdata[d], last_rd[d][0]);
    if (!rv) chk("data_rdata_hold", d, data_rdata[d], last_rd[d][1]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    sat[0] = 64'hFFFF_FFFF;
    sat[1] = 64'd15;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) ref_mem[d][i] = init_word(i);
    rst_n = 1'b0;
    reset_model();
    for (int d = 0; d < 2; d++) begin
      inst_addr[d] = '0; inst_we[d] = 1'b0; inst_be[d] = 4'h0; inst_wdata[d] = 32'h0;
      data_addr[d] = '0; data_we[d] = 1'b0; data_be[d] = 4'h0; data_wdata[d] = 32'h0;
    end
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sustained contention from reset on both arbiters.
    repeat (10) step(1);
    vectors++;
    if (gseq[0] != "IDIDIDIDID") begin
      miscompares++;
      $display("FAIL rr_order dut0: got %s, expected IDIDIDIDID", gseq[0]);
    end
    vectors++;
    if (gseq[1] != "DDDDIDDDDI") begin
      miscompares++;
      $display("FAIL prio_order dut1: got %s, expected DDDDIDDDDI", gseq[1]);
    end
    chk("rr_stalls", 0, {istall0, dstall0}, {32'd5, 32'd5});
    chk("prio_stalls", 1, {56'd0, istall1, dstall1}, {56'd0, 4'd8, 4'd2});
    drain();

    // Single inst read of 0x0010, then reset while its BRAM command is in flight.
    for (int d = 0; d < 2; d++) begin
      granted[d][0] = 1'b0;
      granted[d][1] = 1'b0;
      pend[d][0] = 1'b1;
      t_addr[d][0] = 16'h0010;
      t_we[d][0] = 1'b0;
      t_be[d][0] = 4'hF;
      t_wd[d][0] = 32'h0;
    end
    step(0);
    chk("pre_rst_en", 0, {63'd0, bram_en[0]}, 64'd1);
    chk("pre_rst_addr", 1, bram_addr[1], 64'h4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(0);

    repeat (2000) step(2);
    repeat (100) step(1);
    drain();
    repeat (3) step(0);
    chk("stall_saturated", 1, {60'd0, dstall1}, 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
